// File: rtl/counter_ctrl.sv
// counter_ctrl: takes four raw pushbuttons (up, down, stop, step) and drives
// the enable/direction inputs of the downstream up/down counter.
// Each button is synchronised, debounced and reduced to a one-cycle press
// event. A run/stop/single-step FSM consumes the events. The FSM's outputs
// are registered, so no input reaches an output combinationally.
module counter_ctrl #(
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_stop,
   input  logic       btn_step,
   output logic       enable,
   output logic       direction,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_STOP     = 2'b00,
      ST_RUN_UP   = 2'b01,
      ST_RUN_DOWN = 2'b10,
      ST_STEP     = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Button bit order: 0 = up, 1 = down, 2 = stop, 3 = step
   logic [3:0] raw;
   logic [3:0] sync_p0;
   logic [3:0] sync_p1;
   logic [3:0] deb;
   logic [3:0] deb_d;
   logic [3:0] press;
   logic       ev_up;
   logic       ev_down;
   logic       ev_stop;
   logic       ev_step;
   state_t     fsm;

   assign raw = {btn_step, btn_stop, btn_down, btn_up};

   // Two-flop synchroniser that brings the raw buttons into the clk domain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_deb
      logic [CNT_W-1:0] cnt;
      logic             lvl;

      // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing samples
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt <= '0;
            lvl <= 1'b0;
         end else if (sync_p1[i] == lvl) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            lvl <= sync_p1[i];
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end

      assign deb[i] = lvl;
   end

   // Delayed copy of the debounced levels; a 0->1 step is a press event
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_d <= '0;
      end else begin
         deb_d <= deb;
      end
   end

   // A release (1->0) produces no event
   assign press   = deb & ~deb_d;
   assign ev_up   = press[0];
   assign ev_down = press[1];
   assign ev_stop = press[2];
   assign ev_step = press[3];

   // Run/stop/step FSM. Priority is stop > step > up/down. Simultaneous up and
   // down cancel out. enable and direction are registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm       <= ST_STOP;
         enable    <= 1'b0;
         direction <= 1'b1;
      end else if (ev_stop) begin
         fsm    <= ST_STOP;
         enable <= 1'b0;
      end else begin
         case (fsm)
            ST_STOP, ST_STEP: begin
               if (ev_step) begin
                  fsm    <= ST_STEP;
                  enable <= 1'b1;
               end else if (ev_up && !ev_down) begin
                  fsm       <= ST_RUN_UP;
                  enable    <= 1'b1;
                  direction <= 1'b1;
               end else if (ev_down && !ev_up) begin
                  fsm       <= ST_RUN_DOWN;
                  enable    <= 1'b1;
                  direction <= 1'b0;
               end else begin
                  // A step lasts one cycle; STOP simply holds
                  fsm    <= ST_STOP;
                  enable <= 1'b0;
               end
            end
            ST_RUN_UP, ST_RUN_DOWN: begin
               if (ev_up && !ev_down) begin
                  fsm       <= ST_RUN_UP;
                  enable    <= 1'b1;
                  direction <= 1'b1;
               end else if (ev_down && !ev_up) begin
                  fsm       <= ST_RUN_DOWN;
                  enable    <= 1'b1;
                  direction <= 1'b0;
               end
            end
            default: begin
               fsm    <= ST_STOP;
               enable <= 1'b0;
            end
         endcase
      end
   end

   assign state = fsm;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: drives directed and random pushbutton activity into
// counter_ctrl. Every output is compared against a reference model. The
// model keeps a short sample history per button and applies the FSM rules
// directly.
module tb_counter_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       btn_stop = 1'b0;
   logic       btn_step = 1'b0;
   logic       enable;
   logic       direction;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;

   // Reference model state. hist bit 0 holds the newest raw sample.
   bit [D+1:0] hist [4];
   bit         deb  [4];
   bit         pend [4];
   logic [1:0] m_state;
   bit         m_en;
   bit         m_dir;

   counter_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_stop  (btn_stop),
      .btn_step  (btn_step),
      .enable    (enable),
      .direction (direction),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: {en,dir,state} got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++) begin
         hist[b] = '0;
         deb[b]  = 1'b0;
         pend[b] = 1'b0;
      end
      m_state = 2'b00;
      m_en    = 1'b0;
      m_dir   = 1'b1;
   endtask

   // One clock edge of the model. Events detected at the previous edge act now.
   task automatic model_edge(input bit [3:0] rawv);
      bit up, dn, stp, stpb, all_diff;
      up   = pend[0];
      dn   = pend[1];
      stp  = pend[2];
      stpb = pend[3];
      if (stp) begin
         m_state = 2'b00; m_en = 1'b0;
      end else if (m_state == 2'b00 || m_state == 2'b11) begin
         if (stpb)            begin m_state = 2'b11; m_en = 1'b1; end
         else if (up && !dn)  begin m_state = 2'b01; m_en = 1'b1; m_dir = 1'b1; end
         else if (dn && !up)  begin m_state = 2'b10; m_en = 1'b1; m_dir = 1'b0; end
         else                 begin m_state = 2'b00; m_en = 1'b0; end
      end else begin
         if (up && !dn)       begin m_state = 2'b01; m_dir = 1'b1; end
         else if (dn && !up)  begin m_state = 2'b10; m_dir = 1'b0; end
      end
      // The synchronised level seen at this edge is the raw sample from two edges earlier.
      // The level flips once D such samples in a row differ from it.
      for (int b = 0; b < 4; b++) begin
         hist[b] = {hist[b][D:0], rawv[b]};
         all_diff = 1'b1;
         for (int k = 2; k <= D + 1; k++)
            if (hist[b][k] == deb[b]) all_diff = 1'b0;
         if (all_diff) begin
            deb[b]  = ~deb[b];
            pend[b] = deb[b];
         end else begin
            pend[b] = 1'b0;
         end
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) model_edge({btn_step, btn_stop, btn_down, btn_up});
      else     model_reset();
      #1;
      check(tag, {enable, direction, state}, {m_en, m_dir, m_state});
   endtask

   task automatic set_btns(input bit [3:0] v);
      btn_up   = v[0];
      btn_down = v[1];
      btn_stop = v[2];
      btn_step = v[3];
   endtask

   task automatic idle(input int n);
      set_btns(4'b0000);
      for (int i = 0; i < n; i++) tick("idle");
   endtask

   // Pulls rst low between edges, holds it across one edge, then releases it between edges
   task automatic async_reset_pulse();
      #2 rst = 1'b0;
      model_reset();
      #1 check("async_rst", {enable, direction, state}, 4'b0100);
      tick("in_rst");
      #2 rst = 1'b1;
   endtask

   initial begin
      model_reset();

      // 1: reset state, then a held up press lands on edge 7 exactly
      for (int i = 0; i < 3; i++) tick("reset");
      check("reset_val", {enable, direction, state}, 4'b0100);
      rst = 1'b1;
      set_btns(4'b0001);
      for (int i = 1; i <= 20; i++) begin
         tick("up_hold");
         if (i == 6) check("up_edge6", {enable, direction, state}, 4'b0100);
         if (i == 7) check("up_edge7", {enable, direction, state}, 4'b1101);
      end
      idle(10);
      check("up_release", {enable, direction, state}, 4'b1101);

      // 2: down from RUN_UP, then stop keeps direction
      set_btns(4'b0010);
      for (int i = 1; i <= 10; i++) begin
         tick("down");
         if (i == 7) check("down_edge7", {enable, direction, state}, 4'b1010);
      end
      idle(10);
      set_btns(4'b0100);
      for (int i = 1; i <= 10; i++) begin
         tick("stop");
         if (i == 7) check("stop_edge7", {enable, direction, state}, 4'b0000);
      end
      idle(10);

      // 3: held step gives exactly one STEP cycle
      set_btns(4'b1000);
      for (int i = 1; i <= 15; i++) begin
         tick("step");
         if (i == 6) check("step_edge6", {enable, direction, state}, 4'b0000);
         if (i == 7) check("step_edge7", {enable, direction, state}, 4'b1011);
         if (i == 8) check("step_edge8", {enable, direction, state}, 4'b0000);
      end
      idle(10);
      check("step_after", {enable, direction, state}, 4'b0000);

      // 4: glitch rejection on 3-cycle pulses
      for (int r = 0; r < 5; r++) begin
         set_btns(4'b0001);
         for (int i = 0; i < 3; i++) tick("glitch_hi");
         set_btns(4'b0000);
         for (int i = 0; i < 2; i++) tick("glitch_lo");
         check("glitch", {enable, direction, state}, 4'b0000);
      end
      idle(10);
      check("glitch_end", {enable, direction, state}, 4'b0000);

      // 5: stop beats up from RUN_DOWN; up+down together from STOP is ignored
      set_btns(4'b0010);
      for (int i = 0; i < 8; i++) tick("to_down");
      idle(6);
      check("in_run_down", {enable, direction, state}, 4'b1010);
      set_btns(4'b0101);
      for (int i = 1; i <= 8; i++) begin
         tick("stop_up");
         if (i == 7) check("stop_beats_up", {enable, direction, state}, 4'b0000);
      end
      idle(8);
      set_btns(4'b0011);
      for (int i = 0; i < 10; i++) tick("up_down");
      check("up_down_ignored", {enable, direction, state}, 4'b0000);
      idle(8);

      // 6: asynchronous reset mid-RUN_DOWN, down held through release
      set_btns(4'b0010);
      for (int i = 0; i < 8; i++) tick("pre_rst_down");
      check("pre_rst", {enable, direction, state}, 4'b1010);
      #2 rst = 1'b0;
      model_reset();
      #1 check("async_rst_now", {enable, direction, state}, 4'b0100);
      tick("held_rst");
      tick("held_rst");
      #2 rst = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick("post_rst");
         if (i == 6) check("post_rst_edge6", {enable, direction, state}, 4'b0100);
         if (i == 7) check("post_rst_edge7", {enable, direction, state}, 4'b1010);
      end
      idle(10);

      // Random button activity against the model
      for (int it = 0; it < 250; it++) begin
         bit [3:0] v;
         int       hold;
         if ($urandom_range(0, 2) == 0) v = 4'($urandom_range(0, 15));
         else                           v = 4'(1 << $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) v = 4'b0000;
         hold = $urandom_range(1, 12);
         set_btns(v);
         for (int j = 0; j < hold; j++) tick("rand");
         if ($urandom_range(0, 39) == 0) async_reset_pulse();
      end
      idle(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
